alu_result_buffer: RTL
======================

Name: alu_result_buffer

Overview:
- Downstream stage of the 32-bit ALU. Captures each ALU result, its flags and the command that produced them into a small FIFO.
- Presents captured entries to the consumer (register-file writeback / branch logic) over a valid/ready handshake.
- Keeps a sticky signed-overflow flag for arithmetic commands and a saturating count of accepted operations.
- Decouples the combinational ALU from a consumer that may stall.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has an ALU result this cycle
- in_ready  output  1  buffer can accept an entry this cycle
- in_command  input  3  ALU command that produced the result (`COMMAND_* encodings from constants.v)
- in_result  input  32  ALU result
- in_carryout  input  1  ALU carryout
- in_zero  input  1  ALU zero flag
- in_overflow  input  1  ALU overflow flag
- out_valid  output  1  head entry is available
- out_ready  input  1  consumer takes the head entry
- out_command  output  3  head entry command
- out_result  output  32  head entry result
- out_carryout  output  1  head entry carryout
- out_zero  output  1  head entry zero flag
- out_overflow  output  1  head entry overflow flag
- occupancy  output  log2(DEPTH)+1  number of valid entries
- sticky_overflow  output  1  set when an ADD/SUB entry with overflow=1 has been accepted since the last clear
- op_count  output  CNT_W  accepted entries since the last clear, saturating
- stat_clear  input  1  clears sticky_overflow and op_count

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: occupancy=0, out_valid=0, in_ready=1, sticky_overflow=0, op_count=0. All out_* data fields read 0.
- Reset mid-operation discards every entry. Any push or pop in the reset cycle is ignored.
- Push: occurs when in_valid && in_ready. All five input fields are written at the tail on that rising edge.
- Pop: occurs when out_valid && out_ready. The head advances on that edge.
- in_ready = (occupancy != DEPTH). It is a registered-state function only, with no combinational path from out_ready. When full, a simultaneous pop does not enable a push in the same cycle.
- out_valid = (occupancy != 0). out_* are driven from the head entry and are forced to 0 when empty.
- Latency: a push at edge N is visible on out_* after edge N. There is no same-cycle bypass: an empty buffer never passes in_* straight through.
- Push and pop in the same cycle with 0 < occupancy < DEPTH: occupancy is unchanged and order is preserved.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. occupancy is tracked separately, so full and empty are unambiguous.
- FIFO order is strict. Entries are never reordered or dropped.
- in_* are ignored when no push occurs. out_* stay stable while out_valid && !out_ready.
- sticky_overflow:
  - Set on a push whose in_command is `COMMAND_ADD or `COMMAND_SUB and whose in_overflow=1.
  - Overflow on any other command is stored in the entry but does not set the sticky flag.
  - stat_clear clears it on the next edge. If a qualifying push occurs in the same cycle as stat_clear, the set wins (result 1).
- op_count:
  - Increments by 1 per push and saturates at all-ones.
  - stat_clear and a push in the same cycle give op_count=1.
  - stat_clear without a push gives 0.
- Carryout and zero are stored unmodified for every command. The buffer never reinterprets flags.

Test Plan:
1. Reset, then push ADD result=0x00000003 (carryout 0, zero 0, overflow 0) with out_ready=0.
   -> out_valid=1 one cycle later, out_result=0x00000003, occupancy=1, op_count=1.
2. With out_ready=0, push DEPTH=4 entries of SUB results 1,0,0x80000000,0xFFFFFFFB.
   -> in_ready=0 after the 4th push. A 5th in_valid is not accepted.
   -> Asserting out_ready then pops the entries in that order, and in_ready returns 1 the cycle after the first pop.
3. Hold in_valid=1 and out_ready=1 continuously with occupancy=1 for 10 cycles of distinct results.
   -> occupancy stays 1, output order matches input order, and the write pointer wraps with no loss.
4. Push ADD with overflow=1, then XOR with overflow=1.
   -> sticky_overflow=1 after the ADD.
   -> Issue stat_clear alone: sticky=0.
   -> Then XOR with overflow=1: sticky stays 0.
   -> Then stat_clear in the same cycle as a SUB push with overflow=1: sticky=1, op_count=1.
5. With CNT_W=4, push 17 entries.
   -> op_count saturates at 0xF.
6. With occupancy=3, assert reset for one cycle while in_valid=1 and out_ready=1.
   -> Next cycle occupancy=0, out_valid=0, out_result=0, in_ready=1, op_count=0.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result FIFO that sits after the 32-bit ALU. It keeps each result with its flags and command,
// and also tracks a sticky signed-overflow flag and a saturating count of accepted results.
module alu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_command,
  input  logic [31:0]                in_result,
  input  logic                       in_carryout,
  input  logic                       in_zero,
  input  logic                       in_overflow,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2:0]                 out_command,
  output logic [31:0]                out_result,
  output logic                       out_carryout,
  output logic                       out_zero,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       sticky_overflow,
  output logic [CNT_W-1:0]           op_count,
  input  logic                       stat_clear
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  // ALU command encodings
  localparam logic [2:0] CommandAdd = 3'd0;
  localparam logic [2:0] CommandSub = 3'd1;

  typedef struct packed {
    logic [2:0]  command;
    logic [31:0] result;
    logic        carryout;
    logic        zero;
    logic        overflow;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic                sticky_q, sticky_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push, pop;
  logic                arith_ovf;
  entry_t              head;

  assign in_ready  = (occ_q != OccW'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign arith_ovf = in_overflow && ((in_command == CommandAdd) || (in_command == CommandSub));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
    // A qualifying push in the clear cycle leaves the flag set.
    if (push && arith_ovf) begin
      sticky_d = 1'b1;
    end else if (stat_clear) begin
      sticky_d = 1'b0;
    end
    if (stat_clear) begin
      cnt_d = push ? CNT_W'(1) : '0;
    end else if (push && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= '{command:  in_command,
                           result:   in_result,
                           carryout: in_carryout,
                           zero:     in_zero,
                           overflow: in_overflow};
    end
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_command     = head.command;
  assign out_result      = head.result;
  assign out_carryout    = head.carryout;
  assign out_zero        = head.zero;
  assign out_overflow    = head.overflow;
  assign occupancy       = occ_q;
  assign sticky_overflow = sticky_q;
  assign op_count        = cnt_q;

endmodule
